traffic_intersection_ctrl: RTL and testbench

//  Two-road intersection controller: main road, side road and a pedestrian crossing over the main road.

---
 rtl/traffic_intersection_ctrl.sv | 164 ++++++++++++++++
 tb/tb_traffic_intersection_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_intersection_ctrl.sv
// Two-road intersection controller with all-red clearance, pedestrian WALK
// over the main road, and a flashing night mode. Lamp outputs are registered.
module traffic_intersection_ctrl #(
  parameter int pSECOND_CNT_VALUE = 99,
  parameter int pMAIN_GREEN_VAL   = 14,
  parameter int pMAIN_YELLOW_VAL  = 2,
  parameter int pSIDE_GREEN_VAL   = 9,
  parameter int pSIDE_YELLOW_VAL  = 2,
  parameter int pALLRED_VAL       = 1,
  parameter int pPED_MIN_GREEN    = 4,
  localparam int M0 = (pMAIN_GREEN_VAL > pMAIN_YELLOW_VAL) ? pMAIN_GREEN_VAL : pMAIN_YELLOW_VAL,
  localparam int M1 = (M0 > pSIDE_GREEN_VAL) ? M0 : pSIDE_GREEN_VAL,
  localparam int M2 = (M1 > pSIDE_YELLOW_VAL) ? M1 : pSIDE_YELLOW_VAL,
  localparam int M3 = (M2 > pALLRED_VAL) ? M2 : pALLRED_VAL,
  localparam int CW = (M3 < 1) ? 1 : $clog2(M3 + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          flash_mode,
  input  logic          ped_req,
  output logic          main_green,
  output logic          main_yellow,
  output logic          main_red,
  output logic          side_green,
  output logic          side_yellow,
  output logic          side_red,
  output logic          ped_walk,
  output logic [CW-1:0] count,
  output logic [2:0]    phase
);

  // state    | meaning
  // MAIN_G   | main road green, side red; may be shortened by a pedestrian request
  // MAIN_Y   | main road yellow, side red
  // ALLRED_A | clearance before side road green
  // SIDE_G   | side road green, main red; WALK lit if a request was pending on entry
  // SIDE_Y   | side road yellow, main red
  // ALLRED_B | clearance before main road green; reset state
  // FLASH    | night mode: main yellow and side red blink together
  localparam logic [2:0] MAIN_G   = 3'd0;
  localparam logic [2:0] MAIN_Y   = 3'd1;
  localparam logic [2:0] ALLRED_A = 3'd2;
  localparam logic [2:0] SIDE_G   = 3'd3;
  localparam logic [2:0] SIDE_Y   = 3'd4;
  localparam logic [2:0] ALLRED_B = 3'd5;
  localparam logic [2:0] FLASH    = 3'd6;

  localparam int PW = (pSECOND_CNT_VALUE < 1) ? 1 : $clog2(pSECOND_CNT_VALUE + 1);

  logic [PW-1:0] presc, presc_nxt;
  logic [CW-1:0] count_nxt;
  logic [2:0]    phase_nxt;
  logic          ped_pending, ped_pending_nxt;
  logic          flash_on, flash_on_nxt;
  logic          ped_walk_nxt;
  logic          tick;
  logic [5:0]    lamps, lamps_nxt;

  function automatic logic [2:0] next_phase(input logic [2:0] ph);
    case (ph)
      MAIN_G:   return MAIN_Y;
      MAIN_Y:   return ALLRED_A;
      ALLRED_A: return SIDE_G;
      SIDE_G:   return SIDE_Y;
      SIDE_Y:   return ALLRED_B;
      default:  return MAIN_G;
    endcase
  endfunction

  function automatic logic [CW-1:0] load_val(input logic [2:0] ph);
    case (ph)
      MAIN_G:  return CW'(pMAIN_GREEN_VAL);
      MAIN_Y:  return CW'(pMAIN_YELLOW_VAL);
      SIDE_G:  return CW'(pSIDE_GREEN_VAL);
      SIDE_Y:  return CW'(pSIDE_YELLOW_VAL);
      default: return CW'(pALLRED_VAL);
    endcase
  endfunction

  // {main_g, main_y, main_r, side_g, side_y, side_r}
  function automatic logic [5:0] lamp_decode(input logic [2:0] ph, input logic fl);
    case (ph)
      MAIN_G:  return 6'b100_001;
      MAIN_Y:  return 6'b010_001;
      SIDE_G:  return 6'b001_100;
      SIDE_Y:  return 6'b001_010;
      FLASH:   return {1'b0, fl, 3'b000, fl};
      default: return 6'b001_001;
    endcase
  endfunction

  assign tick = (presc == PW'(pSECOND_CNT_VALUE));

  always_comb begin
    presc_nxt       = presc;
    count_nxt       = count;
    phase_nxt       = phase;
    ped_pending_nxt = ped_pending;
    flash_on_nxt    = flash_on;
    ped_walk_nxt    = ped_walk;
    if (flash_mode && phase != FLASH) begin
      phase_nxt       = FLASH;
      presc_nxt       = '0;
      count_nxt       = '0;
      ped_pending_nxt = 1'b0;
      flash_on_nxt    = 1'b0;
      ped_walk_nxt    = 1'b0;
    end else if (!flash_mode && phase == FLASH) begin
      phase_nxt    = ALLRED_B;
      count_nxt    = CW'(pALLRED_VAL);
      presc_nxt    = '0;
      flash_on_nxt = 1'b0;
    end else begin
      presc_nxt = tick ? '0 : presc + 1'b1;
      if (phase == FLASH) begin
        if (tick) flash_on_nxt = ~flash_on;
      end else begin
        if (tick) begin
          if (count != '0) begin
            count_nxt = count - 1'b1;
          end else begin
            phase_nxt = next_phase(phase);
            count_nxt = load_val(phase_nxt);
          end
        end
        // A request seen this cycle shortens the green immediately, overriding the tick.
        if (phase == MAIN_G && (ped_pending || ped_req) && count > CW'(pPED_MIN_GREEN))
          count_nxt = CW'(pPED_MIN_GREEN);
        if (ped_req) ped_pending_nxt = 1'b1;
        if (phase != SIDE_G && phase_nxt == SIDE_G) begin
          ped_walk_nxt    = ped_pending;
          ped_pending_nxt = ped_req;
        end else if (phase == SIDE_G && phase_nxt != SIDE_G) begin
          ped_walk_nxt = 1'b0;
        end
      end
    end
    lamps_nxt = lamp_decode(phase_nxt, flash_on_nxt);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc       <= '0;
      count       <= CW'(pALLRED_VAL);
      phase       <= ALLRED_B;
      ped_pending <= 1'b0;
      flash_on    <= 1'b0;
      ped_walk    <= 1'b0;
      lamps       <= 6'b001_001;
    end else if (en) begin
      presc       <= presc_nxt;
      count       <= count_nxt;
      phase       <= phase_nxt;
      ped_pending <= ped_pending_nxt;
      flash_on    <= flash_on_nxt;
      ped_walk    <= ped_walk_nxt;
      lamps       <= lamps_nxt;
    end
  end

  assign {main_green, main_yellow, main_red, side_green, side_yellow, side_red} = lamps;

endmodule

// File: tb/tb_traffic_intersection_ctrl.sv
// Scoreboard bench: expected output snapshots (with cycles since the previous
// output change) are queued up front; a monitor pops one on every output change.
module tb_traffic_intersection_ctrl;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       flash_mode = 1'b0;
  logic       ped_req = 1'b0;
  logic       main_green, main_yellow, main_red;
  logic       side_green, side_yellow, side_red;
  logic       ped_walk;
  logic [3:0] count;
  logic [2:0] phase;

  traffic_intersection_ctrl #(.pSECOND_CNT_VALUE(3)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .flash_mode(flash_mode), .ped_req(ped_req),
    .main_green(main_green), .main_yellow(main_yellow), .main_red(main_red),
    .side_green(side_green), .side_yellow(side_yellow), .side_red(side_red),
    .ped_walk(ped_walk), .count(count), .phase(phase)
  );

  always #5 clk = ~clk;

  // {mg, my, mr, sg, sy, sr, walk}
  localparam logic [6:0] L_MG  = 7'b1000010;
  localparam logic [6:0] L_MY  = 7'b0100010;
  localparam logic [6:0] L_AR  = 7'b0010010;
  localparam logic [6:0] L_SG  = 7'b0011000;
  localparam logic [6:0] L_SGW = 7'b0011001;
  localparam logic [6:0] L_SY  = 7'b0010100;
  localparam logic [6:0] L_FL  = 7'b0100010;
  localparam logic [6:0] L_OFF = 7'b0000000;

  typedef struct {
    int         dur;
    logic [2:0] ph;
    logic [3:0] cnt;
    logic [6:0] lamps;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ev_num = 0;
  int last_cyc = 0;
  logic [13:0] prev_snap = '1;
  logic [6:0] lamps_obs;

  assign lamps_obs = {main_green, main_yellow, main_red, side_green, side_yellow, side_red, ped_walk};

  always @(posedge clk) cyc++;

  // monitor: an output change is the DUT presenting a new result
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if ({phase, count, lamps_obs} !== prev_snap) begin
        checks++;
        ev_num++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL event%0d unexpected: ph=%0d cnt=%0d lamps=%b", ev_num, phase, count, lamps_obs);
        end else begin
          e = exp_q.pop_front();
          if (phase !== e.ph || count !== e.cnt || lamps_obs !== e.lamps ||
              (e.dur != 0 && (cyc - last_cyc) != e.dur)) begin
            errors++;
            $display("FAIL event%0d got ph=%0d cnt=%0d lamps=%b dur=%0d, want ph=%0d cnt=%0d lamps=%b dur=%0d",
                     ev_num, phase, count, lamps_obs, cyc - last_cyc, e.ph, e.cnt, e.lamps, e.dur);
          end
        end
        prev_snap = {phase, count, lamps_obs};
        last_cyc  = cyc;
      end
      if (!rst_n) last_cyc = cyc;
    end
  end

  task automatic push(input int d, input logic [2:0] p, input int c, input logic [6:0] l);
    exp_t e;
    e.dur = d; e.ph = p; e.cnt = 4'(c); e.lamps = l;
    exp_q.push_back(e);
  endtask

  task automatic push_phase(input logic [2:0] p, input int v, input logic [6:0] l);
    for (int i = v; i >= 0; i--) push(4, p, i, l);
  endtask

  task automatic push_tail(input logic [6:0] sg_l);
    push_phase(3'd1, 2, L_MY);
    push_phase(3'd2, 1, L_AR);
    push_phase(3'd3, 9, sg_l);
    push_phase(3'd4, 2, L_SY);
    push_phase(3'd5, 1, L_AR);
  endtask

  // main green clipped to 4 in the cycle after count reaches clip_at
  task automatic push_main_clip(input int clip_at);
    for (int i = 14; i >= clip_at; i--) push(4, 3'd0, i, L_MG);
    push(1, 3'd0, 4, L_MG);
    push(3, 3'd0, 3, L_MG);
    for (int i = 2; i >= 0; i--) push(4, 3'd0, i, L_MG);
  endtask

  task automatic wait_obs(input logic [2:0] p, input logic [3:0] c, input logic [6:0] l);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(phase === p && count === c && lamps_obs === l) && n < 3000);
    checks++;
    if (!(phase === p && count === c && lamps_obs === l)) begin
      errors++;
      $display("FAIL wait_state timeout: ph=%0d cnt=%0d lamps=%b, want ph=%0d cnt=%0d lamps=%b",
               phase, count, lamps_obs, p, c, l);
    end
  endtask

  task automatic pulse_ped();
    ped_req = 1'b1;
    @(negedge clk);
    ped_req = 1'b0;
  endtask

  initial begin
    // reset and first free-running cycle
    push(0, 3'd5, 1, L_AR);
    push(4, 3'd5, 0, L_AR);
    push_phase(3'd0, 14, L_MG);
    push_tail(L_SG);
    // request at main count 12
    push_main_clip(12);
    push_tail(L_SGW);
    // request at main count 3, and again during side green
    push_phase(3'd0, 14, L_MG);
    push_tail(L_SGW);
    // pending request clips at main entry; enable dropped at side count 5
    push_main_clip(14);
    push_phase(3'd1, 2, L_MY);
    push_phase(3'd2, 1, L_AR);
    for (int i = 9; i >= 5; i--) push(4, 3'd3, i, L_SGW);
    push(104, 3'd3, 4, L_SGW);
    for (int i = 3; i >= 0; i--) push(4, 3'd3, i, L_SGW);
    push_phase(3'd4, 2, L_SY);
    push_phase(3'd5, 1, L_AR);
    // flash entered from main yellow, then exited
    push_phase(3'd0, 14, L_MG);
    push(4, 3'd1, 2, L_MY);
    push(1, 3'd6, 0, L_OFF);
    push(4, 3'd6, 0, L_FL);
    push(4, 3'd6, 0, L_OFF);
    push(4, 3'd6, 0, L_FL);
    push(1, 3'd5, 1, L_AR);
    push(4, 3'd5, 0, L_AR);
    push(4, 3'd0, 14, L_MG);
    push(4, 3'd0, 13, L_MG);
    // flash again, then reset while flashing
    push(1, 3'd6, 0, L_OFF);
    push(4, 3'd6, 0, L_FL);
    push(0, 3'd5, 1, L_AR);
    push(4, 3'd5, 0, L_AR);
    push(4, 3'd0, 14, L_MG);

    @(negedge clk);
    en = 1'b1;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;

    wait_obs(3'd1, 4'd2, L_MY);
    wait_obs(3'd0, 4'd12, L_MG);
    pulse_ped();

    wait_obs(3'd1, 4'd2, L_MY);
    wait_obs(3'd0, 4'd3, L_MG);
    pulse_ped();
    wait_obs(3'd3, 4'd7, L_SGW);
    pulse_ped();

    wait_obs(3'd0, 4'd4, L_MG);
    wait_obs(3'd3, 4'd5, L_SGW);
    en = 1'b0;
    repeat (100) @(negedge clk);
    en = 1'b1;

    wait_obs(3'd1, 4'd2, L_MY);
    flash_mode = 1'b1;
    wait_obs(3'd6, 4'd0, L_FL);
    wait_obs(3'd6, 4'd0, L_OFF);
    wait_obs(3'd6, 4'd0, L_FL);
    flash_mode = 1'b0;
    wait_obs(3'd0, 4'd13, L_MG);
    flash_mode = 1'b1;
    wait_obs(3'd6, 4'd0, L_FL);

    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (phase !== 3'd5 || count !== 4'd1 || lamps_obs !== L_AR) begin
      errors++;
      $display("FAIL async_reset got ph=%0d cnt=%0d lamps=%b, want ph=5 cnt=1 lamps=%b",
               phase, count, lamps_obs, L_AR);
    end
    flash_mode = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;

    begin
      int n = 0;
      while (exp_q.size() != 0 && n < 500) begin
        @(negedge clk);
        n++;
      end
      repeat (2) @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
        errors++;
        $display("FAIL drain: %0d expected events never seen, want 0", exp_q.size());
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
